// File: rtl/mant_div_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : mant_div_pkg                                       |
// | Description : Shared widths and FSM state type for the           |
// |               sequential significand divider.                    |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
package mant_div_pkg;

   localparam int WIDTH_OPERATORS = 24;
   localparam int FRAC_BITS       = 3;
   localparam int WIDTH_QUOT      = WIDTH_OPERATORS + FRAC_BITS;
   localparam int CNT_W           = $clog2(WIDTH_QUOT);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage : mant_div_pkg
`default_nettype wire

// File: rtl/mant_div_step.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : mant_div_step                                      |
// | Description : One combinational restoring-division iteration.    |
// |               Shifts the next dividend bit into the partial      |
// |               remainder and subtracts the divisor if it fits.    |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module mant_div_step
   import mant_div_pkg::*;
(
   input  logic [WIDTH_OPERATORS-1:0] r_i,
   input  logic                       d_msb_i,
   input  logic [WIDTH_OPERATORS-1:0] y_i,
   output logic [WIDTH_OPERATORS-1:0] r_next_o,
   output logic                       q_bit_o
);

   // The shifted remainder needs one extra bit; after the conditional
   // subtract the result is always below Y and fits back in 24 bits.
   logic [WIDTH_OPERATORS:0]   w_r_shift;
   logic [WIDTH_OPERATORS-1:0] w_diff;

   // Compare/subtract of the shifted remainder against the divisor.
   always_comb begin
      w_r_shift = {r_i, d_msb_i};
      w_diff    = w_r_shift[WIDTH_OPERATORS-1:0] - y_i;
      q_bit_o   = (w_r_shift >= {1'b0, y_i});
      r_next_o  = q_bit_o ? w_diff : w_r_shift[WIDTH_OPERATORS-1:0];
   end

endmodule : mant_div_step
`default_nettype wire

// File: rtl/mant_div_seq.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : mant_div_seq                                       |
// | Description : Sequential unsigned significand divider, one       |
// |               quotient bit per cycle. Produces                   |
// |               floor((X<<3)/Y), the remainder and a sticky bit.   |
// |               Optional MANT_DIV_EARLY_EXIT_EN finishes as soon   |
// |               as the remainder and remaining dividend are zero.  |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module mant_div_seq
   import mant_div_pkg::*;
(
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       in_valid_i,
   output logic                       in_ready_o,
   input  logic [WIDTH_OPERATORS-1:0] X,
   input  logic [WIDTH_OPERATORS-1:0] Y,
   output logic                       out_valid_o,
   input  logic                       out_ready_i,
   output logic [WIDTH_QUOT-1:0]      quot_o,
   output logic [WIDTH_OPERATORS-1:0] rem_o,
   output logic                       sticky_o,
   output logic                       dz_o
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH_QUOT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t                     state_q, state_d;
   logic [WIDTH_QUOT-1:0]      d_q, d_d;
   logic [WIDTH_OPERATORS-1:0] y_q, y_d;
   logic [WIDTH_OPERATORS-1:0] r_q, r_d;
   logic [WIDTH_QUOT-1:0]      quot_q, quot_d;
   logic [CNT_W-1:0]           cnt_q, cnt_d;
   logic                       dz_q, dz_d;

   logic [WIDTH_OPERATORS-1:0] w_r_next;
   logic                       w_q_bit;
   logic                       w_early;

   mant_div_step u_step (
      .r_i      (r_q),
      .d_msb_i  (d_q[WIDTH_QUOT-1]),
      .y_i      (y_q),
      .r_next_o (w_r_next),
      .q_bit_o  (w_q_bit)
   );

`ifdef MANT_DIV_EARLY_EXIT_EN
   // Nothing left to divide: zero remainder and no unconsumed dividend bits.
   assign w_early = (w_r_next == '0) && (d_q[WIDTH_QUOT-2:0] == '0);
`else
   assign w_early = 1'b0;
`endif

   // Next-state and datapath update for the IDLE/BUSY/DONE sequence.
   always_comb begin
      state_d = state_q;
      d_d     = d_q;
      y_d     = y_q;
      r_d     = r_q;
      quot_d  = quot_q;
      cnt_d   = cnt_q;
      dz_d    = dz_q;
      case (state_q)
         IDLE: begin
            if (in_valid_i) begin
               d_d   = {X, {FRAC_BITS{1'b0}}};
               y_d   = Y;
               r_d   = '0;
               cnt_d = CNT_LAST;
               if (Y == '0) begin
                  quot_d  = '1;
                  dz_d    = 1'b1;
                  state_d = DONE;
               end else begin
                  quot_d  = '0;
                  dz_d    = 1'b0;
                  state_d = BUSY;
               end
            end
         end
         BUSY: begin
            r_d    = w_r_next;
            d_d    = {d_q[WIDTH_QUOT-2:0], 1'b0};
            quot_d = {quot_q[WIDTH_QUOT-2:0], w_q_bit};
            if (w_early) begin
               // Remaining quotient bits are all zero; align and finish.
               quot_d  = quot_d << cnt_q;
               state_d = DONE;
            end else if (cnt_q == '0) begin
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         DONE: begin
            if (out_ready_i) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset discards any operation in flight.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         d_q     <= '0;
         y_q     <= '0;
         r_q     <= '0;
         quot_q  <= '0;
         cnt_q   <= '0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         d_q     <= d_d;
         y_q     <= y_d;
         r_q     <= r_d;
         quot_q  <= quot_d;
         cnt_q   <= cnt_d;
         dz_q    <= dz_d;
      end
   end

   assign in_ready_o  = (state_q == IDLE);
   assign out_valid_o = (state_q == DONE);
   assign quot_o      = quot_q;
   assign rem_o       = r_q;
   assign sticky_o    = (r_q != '0);
   assign dz_o        = dz_q;

endmodule : mant_div_seq
`default_nettype wire

// File: tb/tb_mant_div_seq.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : tb_mant_div_seq                                    |
// | Description : Self-checking bench for mant_div_seq: directed     |
// |               cases plus random operands against an arithmetic   |
// |               reference (honours MANT_DIV_EARLY_EXIT_EN).        |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module tb_mant_div_seq;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        in_valid_i = 1'b0;
   logic        in_ready_o;
   logic [23:0] X = '0;
   logic [23:0] Y = '0;
   logic        out_valid_o;
   logic        out_ready_i = 1'b0;
   logic [26:0] quot_o;
   logic [23:0] rem_o;
   logic        sticky_o;
   logic        dz_o;

   int n_cmp = 0;
   int n_err = 0;

   mant_div_seq dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .X           (X),
      .Y           (Y),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .quot_o      (quot_o),
      .rem_o       (rem_o),
      .sticky_o    (sticky_o),
      .dz_o        (dz_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference quotient/remainder from plain integer arithmetic.
   function automatic void model(input logic [23:0] x, input logic [23:0] y,
                                 output logic [26:0] q, output logic [23:0] r);
      longint unsigned d;
      d = longint'(x) * 8;
      if (y == 0) begin
         q = 27'h7FFFFFF;
         r = '0;
      end else begin
         q = 27'(d / longint'(y));
         r = 24'(d % longint'(y));
      end
   endfunction

   // Expected cycles from accept to the first cycle with out_valid_o high.
   function automatic int exp_lat(input logic [23:0] x, input logic [23:0] y);
      longint unsigned d;
      d = longint'(x) * 8;
      if (y == 0) return 1;
`ifdef MANT_DIV_EARLY_EXIT_EN
      for (int k = 1; k < 27; k++) begin
         if (((d >> (27 - k)) % longint'(y) == 0) &&
             ((d & ((64'd1 << (27 - k)) - 1)) == 0))
            return k + 1;
      end
`endif
      return 28;
   endfunction

   task automatic run_div(input logic [23:0] x, input logic [23:0] y,
                          input int hold, input string tag);
      logic [26:0] eq;
      logic [23:0] er;
      int          n;
      model(x, y, eq, er);
      @(negedge clk_i);
      chk({tag, " in_ready idle"}, 32'(in_ready_o), 32'd1);
      X = x;
      Y = y;
      in_valid_i = 1'b1;
      @(posedge clk_i);
      #1;
      // Operands and valid after accept must be ignored.
      X = 24'($urandom);
      Y = 24'($urandom);
      chk({tag, " in_ready busy"}, 32'(in_ready_o), 32'd0);
      n = 0;
      while (!out_valid_o && n < 100) begin
         @(posedge clk_i);
         #1;
         n++;
      end
      in_valid_i = 1'b0;
      chk({tag, " latency"}, 32'(n + 1), 32'(exp_lat(x, y)));
      chk({tag, " quot"}, 32'(quot_o), 32'(eq));
      chk({tag, " rem"}, 32'(rem_o), 32'(er));
      chk({tag, " sticky"}, 32'(sticky_o), 32'(er != 0));
      chk({tag, " dz"}, 32'(dz_o), 32'(y == 0));
      for (int i = 0; i < hold; i++) begin
         @(posedge clk_i);
         #1;
         chk({tag, " hold valid"}, 32'(out_valid_o), 32'd1);
         chk({tag, " hold ready"}, 32'(in_ready_o), 32'd0);
         chk({tag, " hold quot"}, 32'(quot_o), 32'(eq));
      end
      @(negedge clk_i);
      out_ready_i = 1'b1;
      @(posedge clk_i);
      #1;
      out_ready_i = 1'b0;
      chk({tag, " post valid"}, 32'(out_valid_o), 32'd0);
      chk({tag, " post ready"}, 32'(in_ready_o), 32'd1);
      chk({tag, " post quot"}, 32'(quot_o), 32'(eq));
      chk({tag, " post rem"}, 32'(rem_o), 32'(er));
   endtask

   initial begin
      logic [23:0] rx, ry;
      // Reset state.
      #12;
      chk("reset in_ready", 32'(in_ready_o), 32'd1);
      chk("reset out_valid", 32'(out_valid_o), 32'd0);
      chk("reset quot", 32'(quot_o), 32'd0);
      chk("reset rem", 32'(rem_o), 32'd0);
      chk("reset sticky", 32'(sticky_o), 32'd0);
      chk("reset dz", 32'(dz_o), 32'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;

      // Directed cases.
      run_div(24'h800000, 24'h800000, 0, "unit");
      run_div(24'hFFFFFF, 24'h800000, 1, "ffff_half");
      run_div(24'h123456, 24'h000000, 2, "divzero");
      run_div(24'hFFFFFF, 24'h000001, 5, "max_quot");
      run_div(24'h000000, 24'h000003, 0, "zero_dividend");

      // Reset in the middle of BUSY.
      @(negedge clk_i);
      X = 24'hFFFFFF;
      Y = 24'h000001;
      in_valid_i = 1'b1;
      @(posedge clk_i);
      #1;
      in_valid_i = 1'b0;
      repeat (10) @(posedge clk_i);
      #2;
      rst_ni = 1'b0;
      #1;
      chk("midrst in_ready", 32'(in_ready_o), 32'd1);
      chk("midrst out_valid", 32'(out_valid_o), 32'd0);
      chk("midrst quot", 32'(quot_o), 32'd0);
      chk("midrst rem", 32'(rem_o), 32'd0);
      chk("midrst sticky", 32'(sticky_o), 32'd0);
      chk("midrst dz", 32'(dz_o), 32'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      run_div(24'h800000, 24'h800000, 0, "after_rst");

      // Random operands over a spread of divisor magnitudes.
      for (int i = 0; i < 24; i++) begin
         rx = 24'($urandom);
         ry = 24'($urandom) >> $urandom_range(0, 23);
         if (i % 8 == 7) rx = rx & 24'hFFF000;
         run_div(rx, ry, $urandom_range(0, 2), "random");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_mant_div_seq
`default_nettype wire
